debug_text_formatter: RTL and testbench

Sequential text-layout engine that sits directly downstream of the debug signal selection mux in the VGA debug path. On each `start` it walks `debug_addr` across all entries. For each entry it captures the returned `debug_data` and `debug_label`, renders them as a fixed-width ASCII field, and writes the characters one at a time into the VGA character buffer through a ready/valid write port. The VGA scan-out side only reads the character buffer; it never touches the selection mux.

---
 rtl/debug_text_formatter_if.sv | 25 ++
 rtl/debug_text_formatter.sv | 193 +++++++++++++++++++
 tb/tb_debug_text_formatter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_text_formatter_if.sv
// Bundle between the formatter, the debug selection mux and the VGA character buffer.
// Purely wiring: the formatter side uses 'master', the mux/buffer environment uses 'slave'.
// Write handshake is char_we/char_ready; the mux returns debug_data/debug_label combinationally.
interface debug_text_formatter_if;
  logic        start;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic [55:0] debug_label;
  logic        char_we;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, debug_data, debug_label, char_ready,
    output debug_addr, char_we, char_addr, char_data, busy, done
  );

  modport slave (
    output start, debug_data, debug_label, char_ready,
    input  debug_addr, char_we, char_addr, char_data, busy, done
  );
endinterface

// File: rtl/debug_text_formatter.sv
// Walks the debug mux and writes each entry as a 20-char "label:HEXVALUE    " field into the VGA char buffer.
// Latency: first char_we two cycles after start; 21 cycles per entry when the buffer never stalls.
// Backpressure: char_ready low holds char_addr/char_data unchanged; nothing is dropped or repeated.
// Optional build macro DEBUG_FMT_CHANGE_MARK_EN: marks values that changed since the previous refresh with '*'.
module debug_text_formatter #(
  parameter int NUM_ENTRIES     = 32,
  parameter int ENTRIES_PER_ROW = 4,
  parameter int SCREEN_COLS     = 80,
  parameter int BASE_ADDR       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  debug_text_formatter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EMIT} state_t;

  localparam logic [11:0] LP_BASE       = 12'(BASE_ADDR);
  localparam logic [11:0] LP_COLS       = 12'(SCREEN_COLS);
  localparam logic [11:0] LP_FIELD      = 12'd20;
  localparam logic [4:0]  LP_LAST_CHAR  = 5'd19;
  localparam logic [6:0]  LP_LAST_ENTRY = 7'(NUM_ENTRIES - 1);
  localparam logic [6:0]  LP_LAST_COL   = 7'(ENTRIES_PER_ROW - 1);

  state_t      r_state, w_state_nxt;
  logic [6:0]  r_debug_addr, w_debug_addr_nxt;
  logic [6:0]  r_col, w_col_nxt;
  logic [11:0] r_row_base, w_row_base_nxt;
  logic [11:0] r_field_base, w_field_base_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic [55:0] r_label, w_label_nxt;
  logic        r_mark, w_mark_nxt;
  logic        r_char_we, w_char_we_nxt;
  logic [11:0] r_char_addr, w_char_addr_nxt;
  logic [7:0]  r_char_data, w_char_data_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_done, w_done_nxt;
  logic        w_changed;

  // ASCII for one character position of a field.
  function automatic logic [7:0] f_char(input logic [4:0] idx, input logic [55:0] label,
                                        input logic [31:0] data, input logic mark);
    logic [7:0] b;
    logic [3:0] n;
    b = 8'h20;
    n = 4'h0;
    if (idx <= 5'd6) begin
      b = label[8*(6-int'(idx)) +: 8];
      if (b == 8'h00) b = 8'h20;
    end else if (idx == 5'd7) begin
      b = mark ? 8'h2A : 8'h3A;
    end else if (idx <= 5'd15) begin
      n = data[4*(15-int'(idx)) +: 4];
      b = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    end
    return b;
  endfunction

`ifdef DEBUG_FMT_CHANGE_MARK_EN
  localparam int LP_AW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  logic [31:0] r_prev [0:(1<<LP_AW)-1];

  assign w_changed = (bus.debug_data != r_prev[r_debug_addr[LP_AW-1:0]]);

  // Previous-value store, refreshed with each captured value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < (1<<LP_AW); i++) r_prev[i] <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_prev[r_debug_addr[LP_AW-1:0]] <= bus.debug_data;
    end
  end
`else
  assign w_changed = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath update; the row base advances by SCREEN_COLS so no divide is needed.
  always_comb begin
    w_state_nxt      = r_state;
    w_debug_addr_nxt = r_debug_addr;
    w_col_nxt        = r_col;
    w_row_base_nxt   = r_row_base;
    w_field_base_nxt = r_field_base;
    w_idx_nxt        = r_idx;
    w_data_nxt       = r_data;
    w_label_nxt      = r_label;
    w_mark_nxt       = r_mark;
    w_char_we_nxt    = r_char_we;
    w_char_addr_nxt  = r_char_addr;
    w_char_data_nxt  = r_char_data;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // r_done high means the last transfer just completed: the block is still leaving EMIT.
        if (bus.start && !r_done) begin
          w_state_nxt      = S_CAPTURE;
          w_debug_addr_nxt = 7'd0;
          w_busy_nxt       = 1'b1;
          w_col_nxt        = 7'd0;
          w_row_base_nxt   = LP_BASE;
          w_field_base_nxt = LP_BASE;
        end
      end
      S_CAPTURE: begin
        w_data_nxt      = bus.debug_data;
        w_label_nxt     = bus.debug_label;
        w_mark_nxt      = w_changed;
        w_idx_nxt       = 5'd0;
        w_char_we_nxt   = 1'b1;
        w_char_addr_nxt = r_field_base;
        w_char_data_nxt = f_char(5'd0, bus.debug_label, bus.debug_data, w_changed);
        w_state_nxt     = S_EMIT;
      end
      S_EMIT: begin
        if (r_char_we && bus.char_ready) begin
          if (r_idx == LP_LAST_CHAR) begin
            w_char_we_nxt = 1'b0;
            if (r_debug_addr < LP_LAST_ENTRY) begin
              w_debug_addr_nxt = r_debug_addr + 7'd1;
              w_state_nxt      = S_CAPTURE;
              if (r_col == LP_LAST_COL) begin
                w_col_nxt        = 7'd0;
                w_row_base_nxt   = r_row_base + LP_COLS;
                w_field_base_nxt = r_row_base + LP_COLS;
              end else begin
                w_col_nxt        = r_col + 7'd1;
                w_field_base_nxt = r_field_base + LP_FIELD;
              end
            end else begin
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt       = r_idx + 5'd1;
            w_char_addr_nxt = r_char_addr + 12'd1;
            w_char_data_nxt = f_char(r_idx + 5'd1, r_label, r_data, r_mark);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output registers; reset abandons any refresh in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_debug_addr <= '0;
      r_col        <= '0;
      r_row_base   <= '0;
      r_field_base <= '0;
      r_idx        <= '0;
      r_data       <= '0;
      r_label      <= '0;
      r_mark       <= 1'b0;
      r_char_we    <= 1'b0;
      r_char_addr  <= '0;
      r_char_data  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_debug_addr <= w_debug_addr_nxt;
      r_col        <= w_col_nxt;
      r_row_base   <= w_row_base_nxt;
      r_field_base <= w_field_base_nxt;
      r_idx        <= w_idx_nxt;
      r_data       <= w_data_nxt;
      r_label      <= w_label_nxt;
      r_mark       <= w_mark_nxt;
      r_char_we    <= w_char_we_nxt;
      r_char_addr  <= w_char_addr_nxt;
      r_char_data  <= w_char_data_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign bus.debug_addr = r_debug_addr;
  assign bus.char_we    = r_char_we;
  assign bus.char_addr  = r_char_addr;
  assign bus.char_data  = r_char_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_debug_text_formatter.sv
// Directed bench for debug_text_formatter: mux model, character-buffer model, timing and layout checks.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
// With DEBUG_FMT_CHANGE_MARK_EN defined the first refresh after reset expects '*' marks.
module tb_debug_text_formatter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_text_formatter_if bus_if ();

  debug_text_formatter #(
    .NUM_ENTRIES(32), .ENTRIES_PER_ROW(4), .SCREEN_COLS(80), .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

`ifdef DEBUG_FMT_CHANGE_MARK_EN
  localparam logic [7:0] MARK1 = 8'h2A;
`else
  localparam logic [7:0] MARK1 = 8'h3A;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] mem [4096];
  int wr_cnt = 0;
  int first_wr_addr = -1;

  // Selection mux model: combinational from debug_addr.
  always_comb begin
    bus_if.debug_data  = {25'h0, bus_if.debug_addr};
    bus_if.debug_label = {48'h0, "x"};
    case (bus_if.debug_addr)
      7'd0:  begin bus_if.debug_data = 32'h00001234; bus_if.debug_label = {40'h0, "pc"};  end
      7'd1:  begin bus_if.debug_data = 32'h00000005; bus_if.debug_label = {40'h0, "ra"};  end
      7'd5:  begin bus_if.debug_data = 32'hDEADBEEF; bus_if.debug_label = {40'h0, "t0"};  end
      7'd26: begin bus_if.debug_data = 32'h000000A5; bus_if.debug_label = {32'h0, "s10"}; end
      default: ;
    endcase
  end

  // Character buffer model.
  always @(negedge clk) begin
    if (bus_if.char_we === 1'b1 && bus_if.char_ready === 1'b1) begin
      if (wr_cnt == 0) first_wr_addr = int'(bus_if.char_addr);
      mem[bus_if.char_addr] = bus_if.char_data;
      wr_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    wr_cnt = 0;
    first_wr_addr = -1;
  endtask

  // Pulses start and follows the refresh; poke re-pulses start mid-refresh and in the done cycle.
  task automatic run_refresh(input bit poke, output int first_n, output int done_n);
    int n;
    clear_mem();
    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    n = 0; first_n = -1; done_n = -1;
    while (done_n < 0 && n < 3000) begin
      @(negedge clk); n++;
      if (first_n < 0 && bus_if.char_we === 1'b1) first_n = n;
      if (bus_if.done === 1'b1) done_n = n;
      bus_if.start = poke && (n == 300 || bus_if.done === 1'b1);
    end
    @(posedge clk); #1 bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.start = 1'b1;
    bus_if.char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; bus_if.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.char_we !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: we=%b busy=%b done=%b, want 0 0 0", bus_if.char_we, bus_if.busy, bus_if.done);
    end
    checks++;
    if (bus_if.debug_addr !== 7'd0 || bus_if.char_addr !== 12'd0 || bus_if.char_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: debug_addr=%0d char_addr=%0d char_data=%h, want 0 0 00",
               bus_if.debug_addr, bus_if.char_addr, bus_if.char_data);
    end
    @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b, want 0", bus_if.busy);
    end
  endtask

  task automatic test_refresh();
    logic [159:0] exp [3];
    int base [3];
    logic [7:0] want;
    int f, d;
    exp[0] = "     pc:00001234    "; base[0] = 0;
    exp[1] = "     t0:DEADBEEF    "; base[1] = 100;
    exp[2] = "    s10:000000A5    "; base[2] = 520;
    run_refresh(1'b0, f, d);
    checks++;
    if (f != 2) begin errors++; $display("FAIL first_we_cycle: got %0d, want 2", f); end
    checks++;
    if (d != 673) begin errors++; $display("FAIL done_cycle: got %0d, want 673", d); end
    checks++;
    if (wr_cnt != 640) begin errors++; $display("FAIL write_count: got %0d, want 640", wr_cnt); end
    checks++;
    if (first_wr_addr != 0) begin errors++; $display("FAIL first_addr: got %0d, want 0", first_wr_addr); end
    @(negedge clk);
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b, want 0 0", bus_if.done, bus_if.busy);
    end
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 20; i++) begin
        want = (i == 7) ? MARK1 : exp[e][159-8*i -: 8];
        checks++;
        if (mem[12'(base[e] + i)] !== want) begin
          errors++;
          $display("FAIL field_%0d: addr %0d got %h, want %h", e, base[e] + i, mem[12'(base[e] + i)], want);
        end
      end
    end
    checks++;
    if (mem[27] !== MARK1) begin errors++; $display("FAIL mark_first: addr 27 got %h, want %h", mem[27], MARK1); end
    checks++;
    if (mem[635] !== 8'h46 || mem[639] !== 8'h20) begin
      errors++;
      $display("FAIL last_entry: addr635=%h addr639=%h, want 46 20", mem[635], mem[639]);
    end
  endtask

  task automatic test_backpressure();
    logic [159:0] exp0;
    int n, first_n, done_n;
    bit armed;
    exp0 = "     pc:00001234    ";
    clear_mem();
    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    n = 0; first_n = -1; done_n = -1; armed = 1'b0;
    while (done_n < 0 && n < 3000) begin
      @(negedge clk); n++;
      if (first_n < 0 && bus_if.char_we === 1'b1) first_n = n;
      if (bus_if.done === 1'b1) done_n = n;
      if (!armed && bus_if.char_we === 1'b1 && bus_if.char_addr == 12'd2) begin
        armed = 1'b1;
        @(posedge clk); #1 bus_if.char_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk); n++;
          checks++;
          if (bus_if.char_we !== 1'b1 || bus_if.char_addr !== 12'd3 || bus_if.char_data !== 8'h20) begin
            errors++;
            $display("FAIL stall_hold_%0d: we=%b addr=%0d data=%h, want 1 3 20",
                     s, bus_if.char_we, bus_if.char_addr, bus_if.char_data);
          end
          @(posedge clk);
        end
        #1 bus_if.char_ready = 1'b1;
        @(negedge clk); n++;
        checks++;
        if (bus_if.char_addr !== 12'd3) begin
          errors++;
          $display("FAIL stall_accept: addr=%0d, want 3", bus_if.char_addr);
        end
        @(negedge clk); n++;
        checks++;
        if (bus_if.char_addr !== 12'd4 || bus_if.char_data !== 8'h20) begin
          errors++;
          $display("FAIL stall_next: addr=%0d data=%h, want 4 20", bus_if.char_addr, bus_if.char_data);
        end
      end
    end
    checks++;
    if (done_n != 676) begin errors++; $display("FAIL stall_done_cycle: got %0d, want 676", done_n); end
    checks++;
    if (wr_cnt != 640) begin errors++; $display("FAIL stall_write_count: got %0d, want 640", wr_cnt); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (mem[i] !== exp0[159-8*i -: 8]) begin
        errors++;
        $display("FAIL stall_field: addr %0d got %h, want %h", i, mem[i], exp0[159-8*i -: 8]);
      end
    end
    checks++;
    if (mem[27] !== 8'h3A) begin errors++; $display("FAIL mark_second: addr 27 got %h, want 3a", mem[27]); end
  endtask

  task automatic test_start_ignored();
    int f, d, cnt;
    bit saw_busy;
    run_refresh(1'b1, f, d);
    checks++;
    if (d != 673) begin errors++; $display("FAIL poke_done_cycle: got %0d, want 673", d); end
    cnt = wr_cnt;
    saw_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.busy !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy || wr_cnt != 640 || cnt != 640) begin
      errors++;
      $display("FAIL no_restart: busy_seen=%b writes=%0d/%0d, want 0 640/640", saw_busy, cnt, wr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n, f, d, cnt;
    bit saw_busy;
    clear_mem();
    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    n = 0;
    while (bus_if.debug_addr !== 7'd10 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (bus_if.debug_addr !== 7'd10) begin
      errors++;
      $display("FAIL reach_entry10: debug_addr=%0d, want 10", bus_if.debug_addr);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.char_we !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.debug_addr !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset: we=%b busy=%b debug_addr=%0d, want 0 0 0",
               bus_if.char_we, bus_if.busy, bus_if.debug_addr);
    end
    cnt = wr_cnt;
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.busy !== 1'b0 || bus_if.char_we !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy || wr_cnt != cnt) begin
      errors++;
      $display("FAIL no_resume: activity=%b writes %0d->%0d, want 0 unchanged", saw_busy, cnt, wr_cnt);
    end
    run_refresh(1'b0, f, d);
    checks++;
    if (first_wr_addr != 0 || wr_cnt != 640 || d != 673) begin
      errors++;
      $display("FAIL restart_after_reset: first_addr=%0d writes=%0d done=%0d, want 0 640 673",
               first_wr_addr, wr_cnt, d);
    end
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.char_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_refresh();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
